// File: rtl/line_memory_pkg.sv
// Shared definitions for the line-wide backing memory: FSM encoding and byte/line geometry.
`default_nettype none

package line_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int WORD_BYTES          = 4;
    localparam int WORD_SHIFT          = $clog2(WORD_BYTES);
    localparam int DEF_WORDS_PER_LINE  = 4;
    localparam int LINE_BYTES          = WORD_BYTES * DEF_WORDS_PER_LINE;
    localparam int OFFSET_BITS         = $clog2(LINE_BYTES);

    // Byte-offset width of a line for an arbitrary line size.
    function automatic int line_offset_bits(input int words_per_line);
        return $clog2(WORD_BYTES * words_per_line);
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_memory_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, preloaded with word i = i.
`default_nettype none

module mem_word_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    typedef logic [DEPTH_WORDS-1:0][31:0] ram_t;

    function automatic ram_t ram_init();
        ram_t r;
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            r[i] = 32'(i);
        end
        return r;
    endfunction

    // Contents are deliberately outside reset; the preload only gives simulation a known image.
    ram_t mem_q = ram_init();

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/line_memory.sv
// Multi-cycle line memory: accepts a line refill or write-back, waits LATENCY cycles,
// then moves one word per cycle through a single-port RAM and pulses mem_ack.
`default_nettype none

module line_memory
    import line_memory_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int DEPTH_WORDS    = 256,
    parameter int LATENCY        = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mem_cs,
    input  logic                        mem_we,
    input  logic [31:0]                 mem_addr,
    input  logic [32*WORDS_PER_LINE-1:0] mem_wdata,
    output logic [32*WORDS_PER_LINE-1:0] mem_rdata,
    output logic                        mem_busy,
    output logic                        mem_ack
);

    localparam int LINE_W = 32 * WORDS_PER_LINE;
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int BEAT_W = $clog2(WORDS_PER_LINE) + 1;
    localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS_PER_LINE - 1);

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_q,   lat_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [ADDR_W-1:0]   line_q,  line_d;
    logic                we_q,    we_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;
    logic [ADDR_W-1:0]   word_addr;
    logic                addr_unused;

    // Taking only ADDR_W word-address bits is what folds out-of-range lines back modulo depth.
    assign word_addr   = mem_addr[WORD_SHIFT +: ADDR_W];
    assign addr_unused = ^{mem_addr[31:ADDR_W+WORD_SHIFT], mem_addr[WORD_SHIFT-1:0]};
    assign ram_addr    = line_q + ADDR_W'(beat_q);

    always_comb begin
        ram_wdata = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                ram_wdata = wdata_q[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        line_d  = line_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ram_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_cs) begin
                    line_d  = word_addr & LINE_MASK;
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    lat_d   = '0;
                    beat_d  = '0;
                    state_d = (LATENCY == 0) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_XFER;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_XFER: begin
                ram_we = we_q;
                if (!we_q) begin
                    for (int k = 0; k < WORDS_PER_LINE; k++) begin
                        if (beat_q == BEAT_W'(k)) begin
                            rdata_d[32*k +: 32] = ram_rdata;
                        end
                    end
                end
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    mem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign mem_rdata = rdata_q;
    assign mem_busy  = (state_q != ST_IDLE);
    assign mem_ack   = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: three configurations share stimulus, checked against a word-array model.
`default_nettype none

module tb_line_memory;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cs0 = 1'b0, cs1 = 1'b0, cs2 = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [127:0] rd0, rd1;
    logic [31:0]  rd2;
    logic         busy0, busy1, busy2, ack0, ack1, ack2;

    always #5 clock = ~clock;

    line_memory u0 (
        .clock(clock), .reset(reset), .mem_cs(cs0), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rd0), .mem_busy(busy0), .mem_ack(ack0)
    );

    line_memory #(.DEPTH_WORDS(32)) u1 (
        .clock(clock), .reset(reset), .mem_cs(cs1), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rd1), .mem_busy(busy1), .mem_ack(ack1)
    );

    line_memory #(.WORDS_PER_LINE(1), .LATENCY(0)) u2 (
        .clock(clock), .reset(reset), .mem_cs(cs2), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata[31:0]), .mem_rdata(rd2), .mem_busy(busy2), .mem_ack(ack2)
    );

    int           cur_sel = 0;
    logic         s_busy, s_ack;
    logic [127:0] s_rd;

    always_comb begin
        case (cur_sel)
            0:       begin s_busy = busy0; s_ack = ack0; s_rd = rd0; end
            1:       begin s_busy = busy1; s_ack = ack1; s_rd = rd1; end
            default: begin s_busy = busy2; s_ack = ack2; s_rd = {96'b0, rd2}; end
        endcase
    end

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  model [3][256];
    logic [127:0] prev_rd [3];

    function automatic int lat_of(input int s);
        return (s == 2) ? 0 : 3;
    endfunction
    function automatic int wpl_of(input int s);
        return (s == 2) ? 1 : 4;
    endfunction
    function automatic int dep_of(input int s);
        return (s == 1) ? 32 : 256;
    endfunction
    function automatic int base_of(input int s, input logic [31:0] a);
        return (int'(a >> 2) & ~(wpl_of(s) - 1)) % dep_of(s);
    endfunction
    function automatic logic [127:0] exp_line(input int s, input logic [31:0] a);
        logic [127:0] r;
        int b;
        r = '0;
        b = base_of(s, a);
        for (int k = 0; k < wpl_of(s); k++) r[32*k +: 32] = model[s][b + k];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_cs(input int s, input logic v);
        case (s)
            0:       cs0 = v;
            1:       cs1 = v;
            default: cs2 = v;
        endcase
    endtask

    // One transaction; exp_tbl overrides the model expectation when use_tbl is set.
    task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [127:0] wd,
                       input logic [127:0] exp_tbl, input bit use_tbl);
        logic [127:0] exp;
        int b, total;
        b     = base_of(s, a);
        total = lat_of(s) + wpl_of(s);
        if (w) begin
            for (int k = 0; k < wpl_of(s); k++) model[s][b + k] = wd[32*k +: 32];
            exp = prev_rd[s];
        end else begin
            exp = exp_line(s, a);
        end
        if (use_tbl) exp = exp_tbl;
        cur_sel = s; we = w; addr = a; wdata = wd;
        set_cs(s, 1'b1);
        @(posedge clock); #1;
        set_cs(s, 1'b0);
        addr = $urandom; we = ~w; wdata = {$urandom, $urandom, $urandom, $urandom};
        check("busy_at_accept", {127'b0, s_busy}, 128'd1);
        check("ack_at_accept",  {127'b0, s_ack},  128'd0);
        for (int n = 1; n <= total; n++) begin
            @(posedge clock); #1;
            check("ack_timing", {127'b0, s_ack}, {127'b0, (n == total)});
            check("busy_held",  {127'b0, s_busy}, 128'd1);
            if (w) check("rdata_during_write", s_rd, prev_rd[s]);
        end
        check("rdata_at_ack", s_rd, exp);
        prev_rd[s] = exp;
        @(posedge clock); #1;
        check("busy_after_ack", {127'b0, s_busy}, 128'd0);
        check("ack_after_ack",  {127'b0, s_ack},  128'd0);
    endtask

    typedef struct {
        int           sel;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] la, lb, old, wd;
        logic [31:0]  a1, a2;

        for (int s = 0; s < 3; s++) begin
            prev_rd[s] = '0;
            for (int i = 0; i < 256; i++) model[s][i] = 32'(i);
        end

        vecs[0] = '{0, 1'b0, 32'd24, 128'd0, {32'd7, 32'd6, 32'd5, 32'd4}};
        vecs[1] = '{0, 1'b1, 32'd4, {32'hD, 32'hC, 32'hB, 32'h10}, {32'd7, 32'd6, 32'd5, 32'd4}};
        vecs[2] = '{0, 1'b0, 32'd0, 128'd0, {32'hD, 32'hC, 32'hB, 32'h10}};
        vecs[3] = '{1, 1'b1, 32'd0, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 128'd0};
        vecs[4] = '{1, 1'b0, 32'd128, 128'd0, {32'hA4, 32'hA3, 32'hA2, 32'hA1}};
        vecs[5] = '{2, 1'b0, 32'd8, 128'd0, 128'd2};

        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", {125'b0, busy0, busy1, busy2}, 128'd0);
        check("reset_ack",  {125'b0, ack0, ack1, ack2},   128'd0);
        check("reset_rdata0", rd0, 128'd0);
        check("reset_rdata1", rd1, 128'd0);
        check("reset_rdata2", {96'b0, rd2}, 128'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b1);
        end

        for (int i = 0; i < 60; i++) begin
            int s;
            s  = int'($urandom_range(0, 2));
            wd = {$urandom, $urandom, $urandom, $urandom};
            txn(s, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 8 * dep_of(s) - 1)), wd, 128'd0, 1'b0);
        end

        // mem_cs held high: one accept per transaction, second accept after IDLE, address change ignored.
        cur_sel = 0;
        a1 = 32'h20; a2 = 32'h30;
        la = exp_line(0, a1);
        lb = exp_line(0, a2);
        we = 1'b0; addr = a1; cs0 = 1'b1;
        @(posedge clock); #1;
        addr = a2;
        repeat (7) @(posedge clock);
        #1;
        check("held_ack1",   {127'b0, ack0}, 128'd1);
        check("held_rdata1", rd0, la);
        @(posedge clock); #1;
        check("held_idle_busy", {127'b0, busy0}, 128'd0);
        @(posedge clock); #1;
        check("held_reaccept_busy", {127'b0, busy0}, 128'd1);
        repeat (6) @(posedge clock);
        #1;
        check("held_no_early_ack", {127'b0, ack0}, 128'd0);
        cs0 = 1'b0;
        @(posedge clock); #1;
        check("held_ack2",   {127'b0, ack0}, 128'd1);
        check("held_rdata2", rd0, lb);
        prev_rd[0] = lb;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("held_single_accept", {127'b0, busy0}, 128'd0);

        // Reset during beat 2 of a write: beats 0-1 committed, 2-3 lost, no ack.
        old = exp_line(0, 32'h40);
        wd  = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
        we = 1'b1; addr = 32'h40; wdata = wd; cs0 = 1'b1;
        @(posedge clock); #1;
        cs0 = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {127'b0, busy0}, 128'd0);
        check("abort_ack",  {127'b0, ack0},  128'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("abort_no_ack", {127'b0, ack0}, 128'd0);
        end
        check("abort_rdata_cleared", rd0, 128'd0);
        reset = 1'b1;
        for (int s = 0; s < 3; s++) prev_rd[s] = '0;
        model[0][16] = wd[31:0];
        model[0][17] = wd[63:32];
        @(posedge clock); #1;
        txn(0, 1'b0, 32'h40, 128'd0, {old[127:64], wd[63:0]}, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
